// File: rtl/div_sequencer.sv
// div_sequencer: sequential front end for a single-cycle combinational divider.
// It latches the operands and holds them on the divider for a fixed settle
// window. It then registers the quotient and divide-by-zero flag and pulses
// data_resultRDY for one cycle.
module div_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [15:0] data_operandB,
  output logic [31:0] div_operandA,
  output logic [15:0] div_operandB,
  input  logic [31:0] div_result,
  input  logic        div_exception,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_inputRDY,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Loaded on accept so that BUSY lasts SETTLE_CYCLES edges, ending with the capture edge.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_reg;
  state_t      state_next;
  logic [3:0]  cnt_reg;
  logic        accept;
  logic        capture;

  // State register: the synchronous active-low reset returns the FSM to IDLE.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. DONE lasts exactly one cycle and can accept a new request immediately.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (ctrl_DIV) state_next = BUSY;
      end
      BUSY: begin
        if (cnt_reg == 4'd0) state_next = DONE;
      end
      DONE: begin
        if (ctrl_DIV) state_next = BUSY;
        else          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: accept a request when not busy; capture when the settle count expires.
  always_comb begin
    accept  = 1'b0;
    capture = 1'b0;
    case (state_reg)
      IDLE:    accept  = ctrl_DIV;
      DONE:    accept  = ctrl_DIV;
      BUSY:    capture = (cnt_reg == 4'd0);
      default: begin
        accept  = 1'b0;
        capture = 1'b0;
      end
    endcase
  end

  // Settle counter: loaded on accept and counted down while BUSY.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_reg <= 4'd0;
    end else if (accept) begin
      cnt_reg <= CNT_LOAD;
    end else if (state_reg == BUSY && cnt_reg != 4'd0) begin
      cnt_reg <= cnt_reg - 4'd1;
    end
  end

  // Operand latches: they change only on an accepted request, so the divider sees stable inputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_operandA <= 32'd0;
      div_operandB <= 16'd0;
    end else if (accept) begin
      div_operandA <= data_operandA;
      div_operandB <= data_operandB;
    end
  end

  // Result capture: a divide-by-zero result is forced to zero. The registered value holds until the next capture.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_result    <= 32'd0;
      data_exception <= 1'b0;
    end else if (capture) begin
      data_result    <= div_exception ? 32'd0 : div_result;
      data_exception <= div_exception;
    end
  end

  // Handshake flags: resultRDY pulses for one cycle after capture; inputRDY is low only while BUSY.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_resultRDY <= 1'b0;
      data_inputRDY  <= 1'b1;
    end else begin
      data_resultRDY <= capture;
      data_inputRDY  <= (state_next != BUSY);
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed scenarios followed by randomized traffic. Both
// are checked every cycle against a transaction-level model, which tracks
// the accept time and the pending divide.
module tb_div_sequencer;

  localparam int S = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [15:0] data_operandB;
  logic [31:0] div_operandA;
  logic [15:0] div_operandB;
  logic [31:0] div_result;
  logic        div_exception;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_inputRDY;
  logic        data_resultRDY;

  int checks = 0;
  int errors = 0;

  div_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .div_operandA   (div_operandA),
    .div_operandB   (div_operandB),
    .div_result     (div_result),
    .div_exception  (div_exception),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_inputRDY  (data_inputRDY),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  // Signed truncating division. A zero divisor returns 0; the caller raises the exception flag.
  function automatic logic [31:0] quotient(input logic [31:0] a, input logic [15:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) return 32'd0;
    return 32'(sa / sb);
  endfunction

  // Stand-in for the combinational divider.
  always_comb begin
    div_exception = (div_operandB == 16'd0);
    div_result    = quotient(div_operandA, div_operandB);
  end

  // Reference model state.
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_acc_edge = 0;
  logic [31:0] m_opa = 32'd0;
  logic [15:0] m_opb = 16'd0;
  logic [31:0] m_res = 32'd0;
  logic        m_exc = 1'b0;
  logic        m_pulse = 1'b0;
  logic        m_in_rdy = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Advance one clock: update the model from the inputs driven before the edge, then compare at the negedge.
  task automatic step();
    @(posedge clock);
    cyc++;
    if (!reset_n) begin
      m_busy  = 1'b0;
      m_opa   = 32'd0;
      m_opb   = 16'd0;
      m_res   = 32'd0;
      m_exc   = 1'b0;
      m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (m_busy && cyc == m_acc_edge + S) begin
        m_exc   = (m_opb == 16'd0);
        m_res   = m_exc ? 32'd0 : quotient(m_opa, m_opb);
        m_pulse = 1'b1;
        m_busy  = 1'b0;
      end else if (!m_busy && ctrl_DIV) begin
        m_opa      = data_operandA;
        m_opb      = data_operandB;
        m_acc_edge = cyc;
        m_busy     = 1'b1;
      end
    end
    m_in_rdy = !m_busy;
    @(negedge clock);
    check("inputRDY",  32'(data_inputRDY),  32'(m_in_rdy));
    check("resultRDY", 32'(data_resultRDY), 32'(m_pulse));
    check("result",    data_result,         m_res);
    check("exception", 32'(data_exception), 32'(m_exc));
    check("opA",       div_operandA,        m_opa);
    check("opB",       32'(div_operandB),   32'(m_opb));
  endtask

  task automatic drive(input logic c, input logic [31:0] a, input logic [15:0] b, input int n);
    ctrl_DIV      = c;
    data_operandA = a;
    data_operandB = b;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_n       = 1'b0;
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd123;
    data_operandB = 16'd4;
    for (int i = 0; i < 3; i++) step();
    reset_n = 1'b1;
    drive(1'b0, 32'd0, 16'd0, 2);

    // Basic divide: 100 / 7 gives 14.
    drive(1'b1, 32'd100, 16'd7, 1);
    drive(1'b0, 32'd0, 16'd0, 6);
    check("basic_q", data_result, 32'd14);

    // Negative dividend: -100 / 7 gives -14.
    drive(1'b1, 32'hFFFF_FF9C, 16'd7, 1);
    drive(1'b0, 32'd0, 16'd0, 6);
    check("neg_q", data_result, 32'hFFFF_FFF2);

    // Divide by zero, then a normal divide clears the flag.
    drive(1'b1, 32'd5, 16'd0, 1);
    drive(1'b0, 32'd0, 16'd0, 6);
    check("dz_exc", 32'(data_exception), 32'd1);
    drive(1'b1, 32'd9, 16'd3, 1);
    drive(1'b0, 32'd0, 16'd0, 6);
    check("dz_after", data_result, 32'd3);

    // A request that arrives while BUSY is ignored.
    drive(1'b1, 32'd100, 16'd7, 1);
    drive(1'b0, 32'd0, 16'd0, 1);
    drive(1'b1, 32'd50, 16'd5, 1);
    drive(1'b0, 32'd0, 16'd0, 5);
    check("lockout_q", data_result, 32'd14);

    // Back-to-back: a request in the DONE cycle is accepted.
    drive(1'b1, 32'd100, 16'd7, 1);
    drive(1'b0, 32'd0, 16'd0, 4);
    drive(1'b1, 32'd81, 16'd9, 1);
    drive(1'b0, 32'd0, 16'd0, 6);
    check("b2b_q", data_result, 32'd9);

    // Reset mid-operation when cnt is 1, then a normal request.
    drive(1'b1, 32'd100, 16'd7, 1);
    drive(1'b0, 32'd0, 16'd0, 2);
    reset_n = 1'b0;
    drive(1'b1, 32'd77, 16'd7, 1);
    reset_n = 1'b1;
    drive(1'b0, 32'd0, 16'd0, 6);
    drive(1'b1, 32'd64, 16'hFFF8, 1);
    drive(1'b0, 32'd0, 16'd0, 6);
    check("post_rst_q", data_result, 32'hFFFF_FFF8);

    // ctrl_DIV held high continuously.
    drive(1'b1, 32'd1000, 16'd10, 3 * (S + 1));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset_n       = ($urandom_range(0, 99) != 0);
      ctrl_DIV      = ($urandom_range(0, 2) != 0);
      data_operandA = $urandom();
      data_operandB = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom());
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
